// File: rtl/gold_ctrl_pkg.sv
// Shared definitions for the Gold-code sequencer.
// Contents:
//   seq_state_t     - sequencer states (IDLE, LOAD, RUN, DONE)
//   GOLD_N_DEF      - default code length in chips
//   GOLD_LENGTH_DEF - default width of shift value and chip index
package gold_ctrl_pkg;

    localparam int GOLD_N_DEF      = 63;
    localparam int GOLD_LENGTH_DEF = $clog2(GOLD_N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/chip_rate_div.sv
// Programmable chip-rate divider.
// The count runs 0..i_div. o_tick is high in the cycle whose count equals
// i_div. The tick is registered, so it is computed one cycle ahead from the
// count the register will hold next.
// Ports:
//   clk         - clock
//   rst         - synchronous reset, active-high
//   i_clear     - the next count starts from 0 instead of advancing
//   i_en        - the next cycle is a counting cycle (else count and tick are 0)
//   i_div       - chip period minus 1, in clock cycles
//   o_tick      - registered chip tick
//   o_tick_next - value o_tick will take after the next edge
module chip_rate_div
    import gold_ctrl_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_tick_next
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic             r_tick;

    // Next count value and the tick that goes with it.
    always_comb begin
        w_cnt_next = '0;
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (r_cnt == i_div) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + DIV_W'(1);
        end
        o_tick_next = i_en && (w_cnt_next == i_div);
    end

    // Count and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= o_tick_next;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/gold_seq_ctrl.sv
// Gold-code sequencer: hands a code shift to the generator over one
// AXI-stream transfer, paces chips with a programmable divider, frames
// N-chip epochs and only swaps the shift at epoch boundaries.
// Ports:
//   clkin, rst              - clock, synchronous active-high reset
//   start, stop             - begin (IDLE only) / abort sequence
//   shift_i, shift_upd      - shift value and request to apply it at next epoch
//   div_i, periods_i        - chip period minus 1; epochs to run (0 = forever)
//   m_axis_t*               - shift transfer to the generator
//   chip_en, chip_idx       - chip tick and current chip index
//   epoch_strobe, period_cnt- last-chip pulse and completed epoch count
//   busy, done              - LOAD/RUN indicator, completion pulse
// Every output is a register; outputs that depend on the state are loaded
// from the next-state value so they line up with the state they describe.
module gold_seq_ctrl
    import gold_ctrl_pkg::*;
#(
    parameter int N      = GOLD_N_DEF,
    parameter int LENGTH = $clog2(N),
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [LENGTH-1:0] shift_i,
    input  logic              shift_upd,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [CNT_W-1:0]  periods_i,
    output logic [LENGTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              chip_en,
    output logic [LENGTH-1:0] chip_idx,
    output logic              epoch_strobe,
    output logic [CNT_W-1:0]  period_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [LENGTH-1:0] LAST_CHIP = LENGTH'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_per;
    logic [CNT_W-1:0]  r_period_cnt;
    logic [LENGTH-1:0] r_tdata;
    logic [LENGTH-1:0] r_pend_data;
    logic [LENGTH-1:0] r_chip_idx;
    logic [LENGTH-1:0] w_chip_idx_next;
    logic [LENGTH-1:0] w_pend_val;
    logic [CNT_W:0]    w_period_inc;
    logic              r_pend_vld;
    logic              r_stop_pend;
    logic              r_tvalid;
    logic              r_epoch;
    logic              r_done;
    logic              r_busy;
    logic              w_tick;
    logic              w_tick_next;
    logic              w_start_ok;
    logic              w_hs;
    logic              w_last_period;
    logic              w_pend_avail;

    // A request arriving in the epoch_strobe cycle counts for that boundary.
    always_comb begin
        w_start_ok    = start && !stop;
        w_hs          = r_tvalid && m_axis_tready;
        w_period_inc  = {1'b0, r_period_cnt} + (CNT_W + 1)'(1);
        w_last_period = (r_per != '0) && (w_period_inc == {1'b0, r_per});
        w_pend_avail  = r_pend_vld || shift_upd;
        w_pend_val    = shift_upd ? shift_i : r_pend_data;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The transfer always completes; a stop only redirects the exit.
                if (w_hs) begin
                    w_state_next = (r_stop_pend || stop) ? ST_IDLE : ST_RUN;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (r_epoch) begin
                    if (w_last_period) begin
                        w_state_next = ST_DONE;
                    end else if (w_pend_avail) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Chip index the register will hold after the next edge.
    always_comb begin
        w_chip_idx_next = r_chip_idx;
        if ((r_state == ST_IDLE) && w_start_ok) begin
            w_chip_idx_next = '0;
        end else if (w_tick) begin
            w_chip_idx_next = (r_chip_idx == LAST_CHIP) ? '0 : r_chip_idx + LENGTH'(1);
        end else begin
            w_chip_idx_next = r_chip_idx;
        end
    end

    // The divider counts only while the next cycle is a RUN cycle and
    // restarts from 0 on every RUN entry.
    chip_rate_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk        (clkin),
        .rst        (rst),
        .i_clear    (r_state != ST_RUN),
        .i_en       (w_state_next == ST_RUN),
        .i_div      (r_div),
        .o_tick     (w_tick),
        .o_tick_next(w_tick_next)
    );

    // State, configuration, counters and registered outputs.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_per        <= '0;
            r_period_cnt <= '0;
            r_tdata      <= '0;
            r_pend_data  <= '0;
            r_pend_vld   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_chip_idx   <= '0;
            r_tvalid     <= 1'b0;
            r_epoch      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tvalid    <= (w_state_next == ST_LOAD);
            r_busy      <= (w_state_next == ST_LOAD) || (w_state_next == ST_RUN);
            r_done      <= (w_state_next == ST_DONE);
            r_epoch     <= w_tick_next && (w_chip_idx_next == LAST_CHIP);
            r_chip_idx  <= w_chip_idx_next;
            r_stop_pend <= (r_state == ST_LOAD) && (w_state_next == ST_LOAD) &&
                           (r_stop_pend || stop);

            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_tdata      <= shift_i;
                r_div        <= div_i;
                r_per        <= periods_i;
                r_period_cnt <= '0;
            end else begin
                if ((r_state == ST_RUN) && (w_state_next == ST_LOAD)) begin
                    r_tdata <= w_pend_val;
                end else begin
                    r_tdata <= r_tdata;
                end
                if (r_epoch && (r_period_cnt != CNT_MAX)) begin
                    r_period_cnt <= w_period_inc[CNT_W-1:0];
                end else begin
                    r_period_cnt <= r_period_cnt;
                end
            end

            // A request landing on the consuming handshake is newer than the
            // value being transferred, so it stays pending.
            if ((w_state_next == ST_IDLE) || (w_state_next == ST_DONE)) begin
                r_pend_vld <= 1'b0;
            end else if (shift_upd && ((r_state == ST_RUN) || (r_state == ST_LOAD))) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= shift_i;
            end else if (w_hs) begin
                r_pend_vld <= 1'b0;
            end else begin
                r_pend_vld <= r_pend_vld;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign chip_en       = w_tick;
    assign chip_idx      = r_chip_idx;
    assign epoch_strobe  = r_epoch;
    assign period_cnt    = r_period_cnt;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// Self-checking bench for gold_seq_ctrl. A negedge monitor logs handshakes,
// chips and done pulses with their cycle numbers; each test derives the
// expected timeline arithmetically (handshake cycle + k*(div+1), k mod N).
module tb_gold_seq_ctrl;

    localparam int N      = 63;
    localparam int LENGTH = 6;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 16;

    logic              clkin = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [LENGTH-1:0] shift_i;
    logic              shift_upd;
    logic [DIV_W-1:0]  div_i;
    logic [CNT_W-1:0]  periods_i;
    logic [LENGTH-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              chip_en;
    logic [LENGTH-1:0] chip_idx;
    logic              epoch_strobe;
    logic [CNT_W-1:0]  period_cnt;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int hs_cyc[$];
    int hs_data[$];
    int chip_cyc[$];
    int chip_idx_q[$];
    int chip_ep[$];
    int done_cyc[$];
    int done_pc[$];
    int stray_epoch;

    gold_seq_ctrl #(.N(N), .LENGTH(LENGTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clkin(clkin), .rst(rst), .start(start), .stop(stop),
        .shift_i(shift_i), .shift_upd(shift_upd), .div_i(div_i),
        .periods_i(periods_i), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .chip_en(chip_en), .chip_idx(chip_idx), .epoch_strobe(epoch_strobe),
        .period_cnt(period_cnt), .busy(busy), .done(done)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    always @(negedge clkin) begin
        if (m_axis_tvalid && m_axis_tready) begin
            hs_cyc.push_back(cyc);
            hs_data.push_back(int'(m_axis_tdata));
        end
        if (chip_en) begin
            chip_cyc.push_back(cyc);
            chip_idx_q.push_back(int'(chip_idx));
            chip_ep.push_back(int'(epoch_strobe));
        end
        if (epoch_strobe && !chip_en) stray_epoch++;
        if (done) begin
            done_cyc.push_back(cyc);
            done_pc.push_back(int'(period_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic clear_mon();
        hs_cyc.delete(); hs_data.delete();
        chip_cyc.delete(); chip_idx_q.delete(); chip_ep.delete();
        done_cyc.delete(); done_pc.delete();
        stray_epoch = 0;
    endtask

    // Pulse start for one cycle, then scramble the config inputs.
    task automatic do_start(input int s, input int d, input int p);
        shift_i = LENGTH'(s); div_i = DIV_W'(d); periods_i = CNT_W'(p);
        start = 1'b1;
        step(1);
        start = 1'b0;
        shift_i = LENGTH'($urandom); div_i = DIV_W'($urandom); periods_i = CNT_W'($urandom);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; shift_upd = 1'b1; m_axis_tready = 1'b1;
        shift_i = 6'd21; div_i = 16'd0; periods_i = 16'd1;
        step(3);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %0d want 0", m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== 6'd0) begin n_err++; $display("FAIL rst_tdata: got %0d want 0", m_axis_tdata); end
        n_vec++; if (chip_en !== 1'b0) begin n_err++; $display("FAIL rst_chip_en: got %0d want 0", chip_en); end
        n_vec++; if (chip_idx !== 6'd0) begin n_err++; $display("FAIL rst_chip_idx: got %0d want 0", chip_idx); end
        n_vec++; if (epoch_strobe !== 1'b0) begin n_err++; $display("FAIL rst_epoch: got %0d want 0", epoch_strobe); end
        n_vec++; if (period_cnt !== 16'd0) begin n_err++; $display("FAIL rst_period_cnt: got %0d want 0", period_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0d want 0", done); end
        rst = 1'b0; start = 1'b0; shift_upd = 1'b0;
        step(2);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %0d want 0", busy); end
        // reset while a transfer is waiting for ready
        m_axis_tready = 1'b0;
        do_start(7, 0, 1);
        step(2);
        n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 6'd7) begin n_err++; $display("FAIL load_hold: got v=%0d d=%0d want v=1 d=7", m_axis_tvalid, m_axis_tdata); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_vec++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_drop: got v=%0d busy=%0d want 0 0", m_axis_tvalid, busy); end
        step(3);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got %0d want 0", m_axis_tvalid); end
    endtask

    task automatic test_finite_runs();
        int ts[6]; int td[6]; int tp[6];
        ts[0] = 5; td[0] = 0; tp[0] = 2;
        ts[1] = 44; td[1] = 3; tp[1] = 1;
        for (int i = 2; i < 6; i++) begin
            ts[i] = int'($urandom_range(0, 62)); td[i] = int'($urandom_range(0, 4)); tp[i] = int'($urandom_range(1, 2));
        end
        m_axis_tready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int h; int budget; int b; int nchips; int last;
            clear_mon();
            // shift requests while idle must be ignored
            shift_i = 6'd50; shift_upd = 1'b1;
            step(2);
            shift_upd = 1'b0;
            do_start(ts[r], td[r], tp[r]);
            budget = tp[r] * N * (td[r] + 1) + 20;
            b = 0;
            while (done_cyc.size() == 0 && b < budget) begin step(1); b++; end
            n_vec++; if (done_cyc.size() == 0) begin n_err++; $display("FAIL run%0d_timeout: no done in %0d cycles", r, budget); end
            step(3);
            n_vec++; if (hs_cyc.size() != 1) begin n_err++; $display("FAIL run%0d_hs_count: got %0d want 1", r, hs_cyc.size()); end
            h = (hs_cyc.size() > 0) ? hs_cyc[0] : 0;
            n_vec++; if (hs_data.size() == 0 || hs_data[0] != ts[r]) begin n_err++; $display("FAIL run%0d_tdata: got %0d want %0d", r, (hs_data.size() > 0) ? hs_data[0] : -1, ts[r]); end
            nchips = tp[r] * N;
            n_vec++; if (chip_cyc.size() != nchips) begin n_err++; $display("FAIL run%0d_chip_count: got %0d want %0d", r, chip_cyc.size(), nchips); end
            for (int k = 0; k < nchips && k < chip_cyc.size(); k++) begin
                int ec; int ei; int ee;
                ec = h + (k + 1) * (td[r] + 1);
                ei = k % N;
                ee = (ei == N - 1) ? 1 : 0;
                n_vec++;
                if (chip_cyc[k] != ec || chip_idx_q[k] != ei || chip_ep[k] != ee) begin
                    n_err++;
                    $display("FAIL run%0d_chip%0d: got cyc=%0d idx=%0d ep=%0d want cyc=%0d idx=%0d ep=%0d", r, k, chip_cyc[k], chip_idx_q[k], chip_ep[k], ec, ei, ee);
                end
            end
            last = h + nchips * (td[r] + 1);
            n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != last + 1) begin n_err++; $display("FAIL run%0d_done_time: got n=%0d cyc=%0d want n=1 cyc=%0d", r, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, last + 1); end
            n_vec++; if (done_pc.size() == 0 || done_pc[0] != tp[r]) begin n_err++; $display("FAIL run%0d_done_pcnt: got %0d want %0d", r, (done_pc.size() > 0) ? done_pc[0] : -1, tp[r]); end
            n_vec++; if (stray_epoch != 0) begin n_err++; $display("FAIL run%0d_stray_epoch: got %0d want 0", r, stray_epoch); end
            n_vec++; if (busy !== 1'b0 || period_cnt !== CNT_W'(tp[r])) begin n_err++; $display("FAIL run%0d_after: got busy=%0d pcnt=%0d want 0 %0d", r, busy, period_cnt, tp[r]); end
        end
    endtask

    task automatic test_stall_stop();
        int s;
        clear_mon();
        s = int'($urandom_range(0, 62));
        m_axis_tready = 1'b0;
        do_start(s, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            stop = (i == 3);
            n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== LENGTH'(s)) begin n_err++; $display("FAIL stall_c%0d: got v=%0d d=%0d want v=1 d=%0d", i, m_axis_tvalid, m_axis_tdata, s); end
            step(1);
        end
        stop = 1'b0;
        m_axis_tready = 1'b1;
        n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== LENGTH'(s)) begin n_err++; $display("FAIL stall_hs: got v=%0d d=%0d want v=1 d=%0d", m_axis_tvalid, m_axis_tdata, s); end
        step(1);
        n_vec++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stall_exit: got v=%0d busy=%0d want 0 0", m_axis_tvalid, busy); end
        step(40);
        n_vec++; if (chip_cyc.size() != 0 || hs_cyc.size() != 1) begin n_err++; $display("FAIL stall_no_run: got chips=%0d hs=%0d want 0 1", chip_cyc.size(), hs_cyc.size()); end
    endtask

    task automatic test_shift_update();
        int d; int b;
        clear_mon();
        d = int'($urandom_range(0, 2));
        m_axis_tready = 1'b1;
        do_start(int'($urandom_range(0, 62)), d, 0);
        b = 0; while (chip_cyc.size() < 21 && b < 200) begin step(1); b++; end
        shift_i = 6'd17; shift_upd = 1'b1; step(1); shift_upd = 1'b0; shift_i = 6'd3;
        b = 0; while (chip_cyc.size() < 41 && b < 200) begin step(1); b++; end
        shift_i = 6'd9; shift_upd = 1'b1; step(1); shift_upd = 1'b0; shift_i = 6'd4;
        b = 0; while (chip_cyc.size() < 66 && b < 400) begin step(1); b++; end
        n_vec++; if (chip_cyc.size() < 66) begin n_err++; $display("FAIL upd_timeout: got %0d chips want 66", chip_cyc.size()); end
        do_stop();
        n_vec++; if (hs_cyc.size() != 2) begin n_err++; $display("FAIL upd_hs_count: got %0d want 2", hs_cyc.size()); end
        if (hs_cyc.size() >= 2 && chip_cyc.size() >= 64) begin
            int bad;
            n_vec++; if (hs_data[1] != 9) begin n_err++; $display("FAIL upd_tdata: got %0d want 9", hs_data[1]); end
            n_vec++; if (hs_cyc[1] != chip_cyc[62] + 1) begin n_err++; $display("FAIL upd_hs_time: got %0d want %0d", hs_cyc[1], chip_cyc[62] + 1); end
            bad = 0;
            for (int k = 0; k < 63; k++) if (chip_idx_q[k] != k || chip_cyc[k] > hs_cyc[1]) bad++;
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL upd_epoch0_phase: got %0d bad chips want 0", bad); end
            n_vec++; if (chip_idx_q[63] != 0 || chip_cyc[63] != hs_cyc[1] + d + 1) begin n_err++; $display("FAIL upd_restart: got idx=%0d cyc=%0d want idx=0 cyc=%0d", chip_idx_q[63], chip_cyc[63], hs_cyc[1] + d + 1); end
        end
        n_vec++; if (period_cnt !== 16'd1) begin n_err++; $display("FAIL upd_pcnt: got %0d want 1", period_cnt); end
    endtask

    task automatic test_upd_at_strobe();
        int d; int b; int t;
        clear_mon();
        d = int'($urandom_range(0, 3));
        m_axis_tready = 1'b1;
        do_start(int'($urandom_range(0, 62)), d, 0);
        b = 0; while (chip_cyc.size() < 62 && b < 400) begin step(1); b++; end
        n_vec++; if (chip_cyc.size() < 62) begin n_err++; $display("FAIL strobe_timeout: got %0d chips want 62", chip_cyc.size()); end
        t = (chip_cyc.size() >= 62) ? chip_cyc[61] + d + 1 : cyc;
        while (cyc < t) step(1);
        shift_i = 6'd33; shift_upd = 1'b1;
        n_vec++; if (epoch_strobe !== 1'b1) begin n_err++; $display("FAIL strobe_align: got %0d want 1", epoch_strobe); end
        step(1);
        shift_upd = 1'b0; shift_i = 6'd2;
        b = 0; while (hs_cyc.size() < 2 && b < 20) begin step(1); b++; end
        do_stop();
        n_vec++; if (hs_cyc.size() != 2 || hs_data[1] != 33 || hs_cyc[1] != t + 1) begin n_err++; $display("FAIL strobe_load: got n=%0d d=%0d cyc=%0d want n=2 d=33 cyc=%0d", hs_cyc.size(), (hs_data.size() > 1) ? hs_data[1] : -1, (hs_cyc.size() > 1) ? hs_cyc[1] : -1, t + 1); end
    endtask

    task automatic test_stop_restart();
        int d; int d2; int b; int sc; int late; int h;
        clear_mon();
        d = int'($urandom_range(0, 2));
        m_axis_tready = 1'b1;
        do_start(int'($urandom_range(0, 62)), d, 0);
        b = 0; while (chip_cyc.size() < 31 && b < 200) begin step(1); b++; end
        stop = 1'b1; sc = cyc;
        step(1);
        stop = 1'b0;
        n_vec++; if (busy !== 1'b0 || chip_en !== 1'b0) begin n_err++; $display("FAIL stop_now: got busy=%0d chip_en=%0d want 0 0", busy, chip_en); end
        step(10);
        late = 0;
        foreach (chip_cyc[k]) if (chip_cyc[k] > sc) late++;
        n_vec++; if (late != 0 || chip_cyc.size() < 31) begin n_err++; $display("FAIL stop_ceases: got late=%0d chips=%0d want 0 >=31", late, chip_cyc.size()); end
        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        step(3);
        n_vec++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL start_stop_same: got v=%0d busy=%0d want 0 0", m_axis_tvalid, busy); end
        clear_mon();
        d2 = int'($urandom_range(0, 2));
        do_start(1, d2, 1);
        n_vec++; if (chip_idx !== 6'd0 || period_cnt !== 16'd0 || m_axis_tdata !== 6'd1) begin n_err++; $display("FAIL restart_clear: got idx=%0d pcnt=%0d d=%0d want 0 0 1", chip_idx, period_cnt, m_axis_tdata); end
        b = 0; while (done_cyc.size() == 0 && b < 300) begin step(1); b++; end
        n_vec++; if (done_cyc.size() == 0) begin n_err++; $display("FAIL restart_timeout: no done in 300 cycles"); end
        h = (hs_cyc.size() > 0) ? hs_cyc[0] : 0;
        n_vec++; if (chip_cyc.size() != N || chip_idx_q[0] != 0 || chip_cyc[0] != h + d2 + 1) begin n_err++; $display("FAIL restart_first_chip: got n=%0d idx=%0d cyc=%0d want n=%0d idx=0 cyc=%0d", chip_cyc.size(), (chip_idx_q.size() > 0) ? chip_idx_q[0] : -1, (chip_cyc.size() > 0) ? chip_cyc[0] : -1, N, h + d2 + 1); end
        n_vec++; if (done_pc.size() == 0 || done_pc[0] != 1) begin n_err++; $display("FAIL restart_pcnt: got %0d want 1", (done_pc.size() > 0) ? done_pc[0] : -1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; shift_upd = 1'b0; m_axis_tready = 1'b0;
        shift_i = '0; div_i = '0; periods_i = '0;
        stray_epoch = 0;
        test_reset();
        test_finite_runs();
        test_stall_stop();
        test_shift_update();
        test_upd_at_strobe();
        test_stop_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
